// File: rtl/mem_bus_master.sv
// Initiator for the shared tri-state memory bus: turns single/burst read and write
// commands into registered re/we/addr/data bus cycles with valid/ready beat streams.
module mem_bus_master #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8,
  parameter int unsigned LW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          busy,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;   // address of the next write beat
  logic [LW-1:0] cnt;    // beats remaining after the current one
  logic [DW-1:0] wdata;

  // Handshake flags are pure decodes of the state register.
  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign busy      = (state != IDLE);

  // The bus is released whenever no write is being driven.
  assign mem_data = mem_we ? wdata : {DW{1'bz}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      cnt      <= '0;
      wdata    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      done <= 1'b0;
      // A consumed read beat frees the slot unless a new capture refills it below.
      if (rd_valid && rd_ready) rd_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr     <= cmd_addr;
            mem_addr <= cmd_addr;
            cnt      <= cmd_len;
            if (cmd_write) begin
              state <= WRITE;
            end else begin
              state  <= READ;
              mem_re <= 1'b1;
            end
          end
        end

        READ: begin
          if (!rd_valid || rd_ready) begin
            rd_data  <= mem_data;
            rd_valid <= 1'b1;
            mem_addr <= mem_addr + AW'(1);
            if (cnt == '0) begin
              mem_re <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt - LW'(1);
            end
          end
        end

        WRITE: begin
          if (wr_valid) begin
            mem_we   <= 1'b1;
            mem_addr <= addr;
            wdata    <= wr_data;
            addr     <= addr + AW'(1);
            if (cnt == '0) begin
              state <= FLUSH;
            end else begin
              cnt <= cnt - LW'(1);
            end
          end else begin
            mem_we <= 1'b0;
          end
        end

        // Last write beat is on the bus this cycle.
        FLUSH: begin
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a behavioural memory responder on the shared bus.
module tb_mem_bus_master;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          done, busy, mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0]    mem [256];
  logic [AW+DW-1:0] wlog [$];
  logic [DW-1:0]    exp_q [16];
  int n_chk = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always #5 clock = ~clock;

  mem_bus_master #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .busy(busy), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  // Responder: async read while mem_re; a keeper pattern on an idle bus exposes any stray master drive.
  assign mem_data = mem_re ? mem[mem_addr] : (!mem_we ? 16'hC3C3 : 16'hzzzz);

  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
      wlog.push_back({mem_addr, mem_data});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("re_we_excl", 32'(mem_re & mem_we), 32'd0);
    if (!mem_re && !mem_we) chk("bus_idle", 32'(mem_data), 32'h0000C3C3);
    if (done) done_cnt++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_flags"}, 32'({rd_valid, done, busy, mem_re, mem_we, wr_ready}), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] len);
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = len;
    tick;
    cmd_valid = 1'b0;
    chk("cmd_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 40) begin
      tick;
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    tick;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Beat k carries base+k+1; 'gaps' idle cycles precede every odd beat.
  task automatic write_burst(input logic [7:0] a, input logic [3:0] len,
                             input logic [15:0] base, input int gaps);
    int k = 0;
    int idle = 0;
    int guard = 0;
    send_cmd(1'b1, a, len);
    while (k <= int'(len) && guard < 64) begin
      if (k % 2 == 1 && idle < gaps) begin
        wr_valid = 1'b0;
        idle++;
      end else begin
        wr_valid = 1'b1;
        wr_data  = base + 16'(k + 1);
      end
      tick;
      guard++;
      if (wr_valid) begin
        k++;
        idle = 0;
      end else begin
        chk("gap_we", 32'(mem_we), 32'd0);
      end
    end
    wr_valid = 1'b0;
    chk("w_beats", 32'(k), 32'(len) + 32'd1);
    chk("flush_wready", 32'(wr_ready), 32'd0);
    chk("flush_we", 32'(mem_we), 32'd1);
    wait_done("w");
  endtask

  // Consumes len+1 beats against exp_q; holds rd_ready low stall_n cycles while beat stall_beat is offered.
  task automatic read_burst(input logic [7:0] a, input logic [3:0] len,
                            input int stall_beat, input int stall_n);
    int got = 0;
    int cyc = 0;
    int stall = 0;
    int n = 0;
    done_cnt = 0;
    rd_ready = 1'b1;
    send_cmd(1'b0, a, len);
    while (got <= int'(len) && cyc < 200) begin
      if (got == stall_beat && rd_valid && stall <= stall_n) begin
        if (stall > 0) begin
          chk("stall_data", 32'(rd_data), 32'(exp_q[stall_beat]));
          chk("stall_addr", 32'(mem_addr), 32'(8'(a + 8'(stall_beat + 1))));
        end
        rd_ready = (stall >= stall_n);
        stall++;
      end else begin
        rd_ready = 1'b1;
      end
      if (rd_valid && rd_ready) begin
        chk("rd_beat", 32'(rd_data), 32'(exp_q[got]));
        got++;
      end
      tick;
      cyc++;
    end
    chk("rd_count", 32'(got), 32'(len) + 32'd1);
    while (busy && n < 40) begin
      tick;
      n++;
    end
    tick;
    chk("rd_done_cnt", 32'(done_cnt), 32'd1);
    chk("rd_valid_end", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 | 16'(i);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    // Reset at start and mid-idle
    #1 reset = 1'b1;
    #1 check_reset_outs("rst0");
    @(posedge clock); #1 reset = 1'b0;
    tick;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outs("rst_idle");
    reset = 1'b0;
    tick;
    chk("rel2_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single write then single read of 0x10
    wlog.delete();
    send_cmd(1'b1, 8'h10, 4'd0);
    chk("t2_wready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1; wr_data = 16'hBEEF;
    tick;
    wr_valid = 1'b0;
    chk("t2_we", 32'(mem_we), 32'd1);
    chk("t2_addr", 32'(mem_addr), 32'h10);
    chk("t2_data", 32'(mem_data), 32'hBEEF);
    chk("t2_flush_wready", 32'(wr_ready), 32'd0);
    chk("t2_done_early", 32'(done), 32'd0);
    tick;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_we_off", 32'(mem_we), 32'd0);
    chk("t2_mem10", 32'(mem[8'h10]), 32'hBEEF);
    tick;
    chk("t2_done_pulse", 32'(done), 32'd0);
    chk("t2_log_n", 32'(wlog.size()), 32'd1);
    wr_valid = 1'b1; wr_data = 16'h1234; rd_ready = 1'b1;
    tick;
    wr_valid = 1'b0;
    chk("stray_wr", 32'(mem_we), 32'd0);
    send_cmd(1'b0, 8'h10, 4'd0);
    chk("t2_re", 32'(mem_re), 32'd1);
    chk("t2_raddr", 32'(mem_addr), 32'h10);
    chk("t2_rv_c1", 32'(rd_valid), 32'd0);
    tick;
    chk("t2_rv", 32'(rd_valid), 32'd1);
    chk("t2_rdata", 32'(rd_data), 32'hBEEF);
    chk("t2_rdone", 32'(done), 32'd1);
    chk("t2_re_off", 32'(mem_re), 32'd0);
    tick;
    chk("t2_rv_clr", 32'(rd_valid), 32'd0);
    chk("t2_rdone_pulse", 32'(done), 32'd0);

    // Reset mid-read
    rd_ready = 1'b0;
    send_cmd(1'b0, 8'h20, 4'd3);
    tick;
    chk("rr_rv", 32'(rd_valid), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outs("rst_read");
    @(posedge clock); #1 reset = 1'b0;
    tick;
    chk("rr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rr_no_re", 32'(mem_re), 32'd0);

    // Wrapping write burst with gaps
    wlog.delete();
    done_cnt = 0;
    write_burst(8'hFE, 4'd3, 16'h0000, 2);
    chk("t3_log_n", 32'(wlog.size()), 32'd4);
    for (int k = 0; k < 4 && k < wlog.size(); k++)
      chk("t3_log", 32'(wlog[k]), 32'({8'(8'hFE + k), 16'(k + 1)}));
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Wrapping read burst with a 3-cycle stall on beat 2
    for (int k = 0; k < 4; k++) exp_q[k] = 16'(k + 1);
    read_burst(8'hFE, 4'd3, 2, 3);

    // Reset after two of four write beats
    wlog.delete();
    send_cmd(1'b1, 8'hFE, 4'd3);
    wr_valid = 1'b1; wr_data = 16'h00A1;
    tick;
    wr_data = 16'h00A2;
    tick;
    wr_data = 16'h00A3;
    tick;
    chk("t5_we_pre", 32'(mem_we), 32'd1);
    #2 reset = 1'b1;
    #1 chk("t5_we_drop", 32'(mem_we), 32'd0);
    check_reset_outs("t5_rst");
    wr_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    tick;
    chk("t5_log_n", 32'(wlog.size()), 32'd2);
    chk("t5_memFE", 32'(mem[8'hFE]), 32'h00A1);
    chk("t5_memFF", 32'(mem[8'hFF]), 32'h00A2);
    chk("t5_mem00", 32'(mem[8'h00]), 32'h0003);
    chk("t5_mem01", 32'(mem[8'h01]), 32'h0004);
    exp_q[0] = 16'h00A1; exp_q[1] = 16'h00A2; exp_q[2] = 16'h0003; exp_q[3] = 16'h0004;
    read_burst(8'hFE, 4'd3, 99, 0);

    // Maximum-length read burst
    for (int k = 0; k < 16; k++) exp_q[k] = 16'h5A20 + 16'(k);
    read_burst(8'h20, 4'd15, 99, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
